stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Time-keeping core of the stopwatch; consumes the single-cycle tick pulses derived from the clock-divider counters and maintains an MM:SS value in BCD. Run/pause toggling, clear and an adjust mode (manual stepping of minutes or seconds at the adjust tick rate) are handled by a three-state FSM. Digit outputs feed the 7-segment scan logic directly.

## Interface
- MIN_MAX, 59, largest minutes value (1..99); minutes wrap from MIN_MAX to 0
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, 1 Hz count tick
- tick_adj  in  1  one-cycle pulse, adjust-step tick (2 Hz)
- pause_req  in  1  one-cycle pulse; toggles RUN/PAUSED
- clr  in  1  one-cycle pulse; clears time to 00:00
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; adjust target, 0 = seconds, 1 = minutes
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits, registered
- running  out  1  1 in RUN only
- in_adj  out  1  1 in ADJUST only
- rollover  out  1  wrap/saturation indicator (see Configuration)

## Operation
- States: PAUSED (reset state), RUN, ADJUST.
- PAUSED→RUN and RUN→PAUSED on pause_req. Any state→ADJUST while adj=1; ADJUST→PAUSED on adj falling (never straight back to RUN).
- RUN: each tick_1hz adds 1 s. sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to minutes; minutes MIN_MAX→0 is full wrap.
- PAUSED: ticks ignored, value held.
- ADJUST: tick_1hz and pause_req ignored; tick_adj adds 1 to the selected field only, field wraps at its own limit (seconds 59→00, minutes MIN_MAX→00), no carry between fields. sel change takes effect on next tick_adj.
- clr: in any state sets all digits to 0 and deasserts rollover; state unchanged.
- Same-cycle priority: rst > clr > adj entry/exit > pause_req > tick. clr with tick: result 00:00 (tick dropped). pause_req with tick_1hz in RUN: transition to PAUSED, tick dropped. pause_req with tick_1hz in PAUSED: transition to RUN, tick dropped.
- Digits always legal BCD: seconds tens 0..5, ones 0..9; minutes 0..MIN_MAX.

## Timing
- Reset (rst=0 at clk edge): all digits 0, state PAUSED, running=0, in_adj=0, rollover=0. Reset mid-count discards value.
- All outputs registered; digit change visible 1 cycle after the tick/clr edge.
- State outputs (running, in_adj) update 1 cycle after the causing input.
- Ticks are single-cycle; a tick held high N cycles counts N times (no edge detect inside the block).
- Full carry chain 59:59→00:00 completes in one cycle.

## Configuration
- STOPWATCH_SATURATE_EN defined: in RUN, tick at MIN_MAX:59 holds the value; rollover goes high and stays high until clr or rst. ADJUST stepping still wraps per field.
- Undefined: MIN_MAX:59 wraps to 00:00 and rollover pulses high for exactly one cycle coincident with the 00:00 output.

## Structure
- stopwatch_pkg: state enum (PAUSED/RUN/ADJUST), digit limits (SEC_TENS_MAX=5, ONES_MAX=9), BCD digit type.
- One sub-module: bcd_digit, a mod-N BCD counter with inc, clr, carry-out; four instances (minute limits derived from MIN_MAX).

## Test plan
- Reset, pause_req, 75 tick_1hz -> digits 01:15, running=1.
- Preload 59:58 in RUN, 2 ticks -> 59:59 then 00:00, rollover one-cycle pulse (macro undefined); with STOPWATCH_SATURATE_EN -> holds 59:59, rollover stays 1 until clr.
- RUN at 00:10, pause_req, 5 ticks, pause_req, 3 ticks -> 00:13; pause_req+tick same cycle -> tick dropped.
- adj=1, sel=0, 62 tick_adj from 00:00 -> 00:02, minutes untouched; sel=1, 3 tick_adj -> 03:02; tick_1hz ignored; adj=0 -> PAUSED.
- clr coincident with tick_1hz at 12:34 in RUN -> 00:00, state RUN; clr in ADJUST -> 00:00, stays ADJUST.
- rst=0 mid-RUN at 07:07 -> next cycle 00:00, PAUSED, all flags 0.

Source files
------------

// File: rtl/stopwatch_counter_pkg.sv
// Shared types and digit limits for the stopwatch time-keeping core.
// Imported by the interface, the BCD digit counter and the top level.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX     = 4'd9;

    function automatic bcd_t tens_of(input int unsigned value);
        return bcd_t'(value / 10);
    endfunction

    function automatic bcd_t ones_of(input int unsigned value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses/levels into the stopwatch core and its registered BCD digits,
// status flags and debug state out of it.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    // Inputs carry no valid/ready: tick_1hz, tick_adj, pause_req and clr are
    // sampled every cycle they are high (one event per high cycle); adj and sel
    // are levels. All outputs are registered and always valid.
    logic      tick_1hz;
    logic      tick_adj;
    logic      pause_req;
    logic      clr;
    logic      adj;
    logic      sel;
    bcd_t      min_tens;
    bcd_t      min_ones;
    bcd_t      sec_tens;
    bcd_t      sec_ones;
    logic      running;
    logic      in_adj;
    logic      rollover;
    sw_state_e state_dbg;

    modport master (
        output tick_1hz, tick_adj, pause_req, clr, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, in_adj, rollover, state_dbg
    );

    modport slave (
        input  tick_1hz, tick_adj, pause_req, clr, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, in_adj, rollover, state_dbg
    );

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// Single BCD digit counting 0..limit_i with synchronous clear and a
// combinational carry-out that fires when an increment wraps the digit.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  bcd_t limit_i,
    output bcd_t digit_o,
    output logic carry_o
);

    bcd_t digit_q, digit_d;
    logic at_limit;

    always_comb begin
        // >= keeps the digit legal if the limit drops below the current value
        at_limit = (digit_q >= limit_i);
        carry_o  = inc_i && at_limit;
        digit_d  = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (inc_i) begin
            digit_d = at_limit ? bcd_t'(0) : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS BCD core with PAUSED/RUN/ADJUST control.
// Define STOPWATCH_SATURATE_EN to hold at MIN_MAX:59 with a sticky rollover flag.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX = 59
) (
    input logic                clk,
    input logic                rst,
    stopwatch_counter_if.slave sw
);

    localparam bcd_t MIN_TENS_MAX = tens_of(MIN_MAX);
    localparam bcd_t MIN_ONES_TOP = ones_of(MIN_MAX);

    sw_state_e state_q, state_d;
    logic      run_tick;
    logic      adj_step;
    logic      hold;
    logic      rollover_q, rollover_d;

    bcd_t sec_ones, sec_tens, min_ones, min_tens;
    bcd_t min_ones_limit;
    logic sec_ones_carry, sec_tens_carry, min_ones_carry, min_tens_carry;
    logic sec_inc, min_inc, wrap_evt;

    // Priority: clr freezes state and drops ticks, then adj entry/exit,
    // then pause_req, and only then a count tick.
    always_comb begin
        state_d  = state_q;
        run_tick = 1'b0;
        adj_step = 1'b0;
        if (!sw.clr) begin
            if (sw.adj) begin
                state_d  = ADJUST;
                adj_step = (state_q == ADJUST) && sw.tick_adj;
            end else if (state_q == ADJUST) begin
                state_d = PAUSED;
            end else if (sw.pause_req) begin
                state_d = (state_q == RUN) ? PAUSED : RUN;
            end else begin
                run_tick = (state_q == RUN) && sw.tick_1hz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    // Seconds carry only reaches minutes while running; adjust steps one field.
    assign sec_inc        = (run_tick && !hold) || (adj_step && !sw.sel);
    assign min_inc        = (run_tick && !hold && sec_tens_carry) || (adj_step && sw.sel);
    assign min_ones_limit = (min_tens == MIN_TENS_MAX) ? MIN_ONES_TOP : ONES_MAX;
    assign wrap_evt       = run_tick && min_tens_carry;

    bcd_digit u_sec_ones (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sw.clr),
        .inc_i   (sec_inc),
        .limit_i (ONES_MAX),
        .digit_o (sec_ones),
        .carry_o (sec_ones_carry)
    );

    bcd_digit u_sec_tens (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sw.clr),
        .inc_i   (sec_ones_carry),
        .limit_i (SEC_TENS_MAX),
        .digit_o (sec_tens),
        .carry_o (sec_tens_carry)
    );

    bcd_digit u_min_ones (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sw.clr),
        .inc_i   (min_inc),
        .limit_i (min_ones_limit),
        .digit_o (min_ones),
        .carry_o (min_ones_carry)
    );

    bcd_digit u_min_tens (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sw.clr),
        .inc_i   (min_ones_carry),
        .limit_i (MIN_TENS_MAX),
        .digit_o (min_tens),
        .carry_o (min_tens_carry)
    );

`ifdef STOPWATCH_SATURATE_EN
    logic at_top;

    assign at_top = (min_tens == MIN_TENS_MAX) && (min_ones == MIN_ONES_TOP) &&
                    (sec_tens == SEC_TENS_MAX) && (sec_ones == ONES_MAX);
    assign hold   = at_top;

    always_comb begin
        rollover_d = rollover_q || (run_tick && at_top) || wrap_evt;
        if (sw.clr) begin
            rollover_d = 1'b0;
        end
    end
`else
    assign hold = 1'b0;

    always_comb begin
        rollover_d = wrap_evt;
        if (sw.clr) begin
            rollover_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= rollover_d;
        end
    end

    assign sw.min_tens  = min_tens;
    assign sw.min_ones  = min_ones;
    assign sw.sec_tens  = sec_tens;
    assign sw.sec_ones  = sec_ones;
    assign sw.running   = (state_q == RUN);
    assign sw.in_adj    = (state_q == ADJUST);
    assign sw.rollover  = rollover_q;
    assign sw.state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomized and directed bench for stopwatch_counter against a seconds-based
// reference model; honours STOPWATCH_SATURATE_EN like the design.
module tb_stopwatch_counter;

    localparam int MIN_MAX = 59;

    logic clk;
    logic rst;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .MIN_MAX (MIN_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    logic [18:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // reference model: whole minutes/seconds and a 0/1/2 mode code
    int m_min   = 0;
    int m_sec   = 0;
    int m_mode  = 0;   // 0 paused, 1 running, 2 adjusting
    bit m_roll  = 1'b0;
    logic cur_adj = 1'b0;
    logic cur_sel = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};
    endfunction

    task automatic model_update(input logic r, t1, ta, pr, c, a, s);
        int total;
        if (!r) begin
            m_min = 0; m_sec = 0; m_mode = 0; m_roll = 1'b0;
        end else if (c) begin
            m_min = 0; m_sec = 0; m_roll = 1'b0;
        end else begin
`ifndef STOPWATCH_SATURATE_EN
            m_roll = 1'b0;
`endif
            if (a) begin
                if (m_mode == 2 && ta) begin
                    if (s) m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                    else   m_sec = (m_sec + 1) % 60;
                end
                m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (pr) begin
                m_mode = (m_mode == 1) ? 0 : 1;
            end else if (m_mode == 1 && t1) begin
                total = m_min * 60 + m_sec + 1;
                if (total > MIN_MAX * 60 + 59) begin
                    m_roll = 1'b1;
`ifndef STOPWATCH_SATURATE_EN
                    m_min = 0; m_sec = 0;
`endif
                end else begin
                    m_min = total / 60;
                    m_sec = total % 60;
                end
            end
        end
    endtask

    // driver: apply one cycle of inputs, advance model, compare after the edge
    task automatic step(input logic r, t1, ta, pr, c, a, s);
        logic [18:0] e;
        rst             = r;
        sw_if.tick_1hz  = t1;
        sw_if.tick_adj  = ta;
        sw_if.pause_req = pr;
        sw_if.clr       = c;
        sw_if.adj       = a;
        sw_if.sel       = s;
        @(posedge clk);
        model_update(r, t1, ta, pr, c, a, s);
        exp_q.push_back({to_bcd(m_min), to_bcd(m_sec), m_mode == 1, m_mode == 2, m_roll});
        #1;
        e = exp_q.pop_front();
        check("digits", 32'(dut_digits()), 32'(e[18:3]));
        check("flags", 32'({sw_if.running, sw_if.in_adj, sw_if.rollover}), 32'(e[2:0]));
    endtask

    task automatic pulse(input logic t1, ta, pr, c);
        step(1'b1, t1, ta, pr, c, cur_adj, cur_sel);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adj_ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_digits", 32'(dut_digits()), 32'h0000);
        check("reset_flags", 32'({sw_if.running, sw_if.in_adj, sw_if.rollover}), 32'h0);

        // start and count 75 s
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(75);
        check("run_0115", 32'(dut_digits()), 32'h0115);
        check("run_running", 32'(sw_if.running), 32'h1);

        // preload 59:58 through adjust mode, then run across the top
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        cur_adj = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        check("adj_entry", 32'(sw_if.in_adj), 32'h1);
        cur_sel = 1'b0; adj_ticks(58);
        cur_sel = 1'b1; adj_ticks(59);
        check("preload_5958", 32'(dut_digits()), 32'h5958);
        cur_adj = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("top_5959", 32'(dut_digits()), 32'h5959);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_SATURATE_EN
        check("sat_hold", 32'(dut_digits()), 32'h5959);
        check("sat_roll", 32'(sw_if.rollover), 32'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_roll_sticky", 32'(sw_if.rollover), 32'h1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_roll_clr", 32'(sw_if.rollover), 32'h0);
`else
        check("wrap_0000", 32'(dut_digits()), 32'h0000);
        check("wrap_roll", 32'(sw_if.rollover), 32'h1);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_roll_end", 32'(sw_if.rollover), 32'h0);
`endif

        // pause / resume
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(10);
        check("run_0010", 32'(dut_digits()), 32'h0010);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(5);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        check("pause_0013", 32'(dut_digits()), 32'h0013);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("pause_tick_drop", 32'({dut_digits(), 3'(sw_if.running)}), {16'h0013, 3'h0});
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("resume_tick_drop", 32'({dut_digits(), 3'(sw_if.running)}), {16'h0013, 3'h1});

        // adjust stepping
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        cur_adj = 1'b1; cur_sel = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        adj_ticks(62);
        check("adj_sec_wrap", 32'(dut_digits()), 32'h0002);
        cur_sel = 1'b1;
        adj_ticks(3);
        check("adj_min", 32'(dut_digits()), 32'h0302);
        ticks(4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("adj_ignore", 32'({dut_digits(), 3'(sw_if.in_adj)}), {16'h0302, 3'h1});
        cur_adj = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        check("adj_exit", 32'({sw_if.running, sw_if.in_adj}), 32'h0);

        // clr beats tick in RUN, clr in ADJUST keeps state
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        cur_adj = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        cur_sel = 1'b0; adj_ticks(34);
        cur_sel = 1'b1; adj_ticks(12);
        cur_adj = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_1234", 32'(dut_digits()), 32'h1234);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_tick", 32'({dut_digits(), 3'(sw_if.running)}), {16'h0000, 3'h1});
        cur_adj = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        adj_ticks(5);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_adj", 32'({dut_digits(), 3'(sw_if.in_adj)}), {16'h0000, 3'h1});

        // reset mid-run at 07:07
        cur_sel = 1'b0; adj_ticks(5);
        cur_sel = 1'b1; adj_ticks(7);
        cur_adj = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);
        check("run_0707", 32'(dut_digits()), 32'h0707);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_run", 32'({dut_digits(), sw_if.running, sw_if.in_adj, sw_if.rollover}), 32'h0);

        // randomized traffic
        cur_adj = 1'b0; cur_sel = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)  cur_adj = ~cur_adj;
            if ($urandom_range(0, 99) < 10) cur_sel = ~cur_sel;
            step($urandom_range(0, 399) != 0,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2,
                 cur_adj, cur_sel);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
